vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-port VRAM access controller between the text-mode VGA scanout and the CPU bus. VGA character fetches (one word per 8 pixel clocks during active video) always win; CPU reads and writes are queued in a small command FIFO and issued in free cycles. An optional clear engine fills the whole 80×60 text buffer with one word without CPU involvement. The block sits between the VGA text controller, the CPU I/O decoder and the VRAM (asynchronous-read distributed RAM).

## Interface
- `ADDR_W`, 13: VRAM word address width.
- `DATA_W`, 11: VRAM word width: `{color[2:0], spare, char[6:0]}`.
- `VRAM_WORDS`, 4800: valid words, 80 cols × 60 rows; addresses ≥ this are out of range.
- `WQ_DEPTH`, 4: command FIFO depth, a power of two ≥ 2.

Ports:
- `vga_clk` in 1: the only clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `vga_rdn` in 1: active-low VGA fetch request for this cycle.
- `vga_addr` in ADDR_W: VGA fetch address.
- `vram_out` out DATA_W: read data to the VGA controller; equals `ram_dout`.
- `cpu_req` in 1: CPU command valid.
- `cpu_we` in 1: 1 for write, 0 for read.
- `cpu_addr` in ADDR_W: CPU word address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_ready` out 1: command accepted when `cpu_req && cpu_ready`.
- `cpu_rdata` out DATA_W: registered read data.
- `cpu_rvalid` out 1: one-cycle pulse qualifying `cpu_rdata`.
- `clr_start` in 1: clear request pulse (`VRAM_CLEAR_EN` only).
- `clr_data` in DATA_W: fill word, sampled with `clr_start`.
- `clr_busy` out 1: clear sequence in progress.
- `ram_addr` out ADDR_W: VRAM address, combinational mux.
- `ram_we` out 1: VRAM write enable, combinational.
- `ram_din` out DATA_W: VRAM write data.
- `ram_dout` in DATA_W: VRAM asynchronous read data.

## Operation
- **Port priority:** VGA, then clear engine, then FIFO head.
- **VGA cycle** (`vga_rdn == 0`):
  - `ram_addr = vga_addr`, `ram_we = 0`.
  - No CPU or clear access is issued that cycle.
- **Command FIFO:**
  - Each entry holds `{we, addr, wdata}`.
  - `cpu_ready = ~full && state == IDLE`. `full` comes from the registered count, so no push occurs at full even if a pop happens the same cycle.
  - A push and a pop in the same cycle leave the count unchanged.
- **Issue** (`vga_rdn == 1`, FIFO non-empty, state IDLE): the head drives `ram_addr`/`ram_we`/`ram_din` and is popped at the clock edge.
  - Write: `ram_we = 1` if `addr < VRAM_WORDS`. Out-of-range writes are popped with `ram_we = 0` (silently dropped).
  - Read: `cpu_rdata <= ram_dout` (or 0 if out of range) and `cpu_rvalid <= 1` for one cycle.
  - Commands execute strictly in acceptance order, so read-after-write returns the new data.
- **States:**
  - IDLE: on `clr_start`, latch `clr_data` and go to DRAIN.
  - DRAIN: keep issuing the FIFO; when it is empty, go to CLEAR with `clr_ptr = 0`.
  - CLEAR: in each non-VGA cycle write `clr_data` to `clr_ptr` and increment. After the write to `VRAM_WORDS-1`, return to IDLE.
  - `clr_busy = (state != IDLE)`. `clr_start` outside IDLE is ignored.
- **Reset:** the FIFO is flushed, any clear in progress is aborted, and state returns to IDLE. Partially written VRAM is left as is.

## Timing
- **Reset values:**
  - `cpu_ready = 0` during reset, then 1 in the first cycle after reset.
  - `cpu_rdata = 0`, `cpu_rvalid = 0`, `clr_busy = 0`.
  - `ram_we = 0`; `ram_addr` follows `vga_addr`.
- **Latency:**
  - A command accepted in cycle T is issued no earlier than T+1.
  - Its read data is valid in T+2 at the earliest.
  - Each VGA-occupied cycle adds one cycle.
- **VGA path:** `vram_out` is combinational from `vga_addr`, with zero added latency. The VGA fetch is never stalled.
- **Clear duration:** 4800 write cycles plus VGA-stolen cycles (about 1/8 of active-video cycles).

## Configuration
- **`VRAM_CLEAR_EN` defined:** DRAIN/CLEAR states and `clr_ptr` logic are present.
- **`VRAM_CLEAR_EN` undefined:**
  - The state machine is removed.
  - `clr_start` and `clr_data` are ignored.
  - `clr_busy` is tied to 0; `cpu_ready = ~full`.
  - Ports are unchanged.

## Test plan
- **Write, idle VGA:** write 0x7_41 to addr 0x0005 with `vga_rdn = 1` throughout. Expect `ram_we = 1`, `ram_addr = 0x0005`, `ram_din = 0x741` in the cycle after acceptance; a following read returns `cpu_rdata = 0x741` with a single `cpu_rvalid` pulse.
- **VGA collision:** hold `vga_rdn = 0` for 3 cycles while 2 writes are queued. Expect `ram_addr = vga_addr` and `ram_we = 0` for all 3 cycles; the writes issue in the next 2 free cycles, in order.
- **FIFO full:** push 4 writes while `vga_rdn = 0`. Expect `cpu_ready = 0`, and a 5th request is held, not lost. Release VGA; expect exactly 4 then 5 writes, in order.
- **Out of range:** write to 4800 and to 8191. Expect no `ram_we` pulse. A read of 4800 returns 0 with `cpu_rvalid`.
- **Clear with backlog** (`VRAM_CLEAR_EN`): queue 2 writes, then pulse `clr_start` with fill 0x020.
  - The 2 writes issue first.
  - Then addresses 0 through 4799 are each written with 0x020 exactly once, skipping VGA cycles.
  - `clr_busy` drops after address 4799; `cpu_ready` is low throughout the clear.
- **Reset mid-clear:** assert `rst` while `clr_ptr = 100`. Expect the next cycle to show `clr_busy = 0`, `ram_we = 0`, FIFO empty and `cpu_ready = 1` after reset is released.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM access arbiter (VGA fetch > clear engine > CPU command FIFO).
// Define VRAM_CLEAR_EN to build the fill engine; without it clr_* inputs are ignored and clr_busy is 0.
module vram_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 11,
  parameter int VRAM_WORDS = 4800,
  parameter int WQ_DEPTH   = 4
) (
  input  logic              vga_clk,
  input  logic              rst,
  input  logic              vga_rdn,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vram_out,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_data,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  localparam int PTR_W = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VRAM_WORDS - 1);

  logic [ENT_W-1:0]  fifo_mem [WQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic              full, empty, push, issue;
  logic [ENT_W-1:0]  head;
  logic              head_we, head_in_range;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic              idle, clr_access;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_wdata;

  assign full  = (count_reg == (PTR_W+1)'(WQ_DEPTH));
  assign empty = (count_reg == '0);

  assign head          = fifo_mem[rd_ptr_reg];
  assign head_we       = head[ENT_W-1];
  assign head_addr     = head[DATA_W +: ADDR_W];
  assign head_wdata    = head[DATA_W-1:0];
  assign head_in_range = (head_addr <= LAST_ADDR);

  // Reset is folded in combinationally so nothing is accepted or written while it is held.
  assign cpu_ready = ~rst & ~full & idle;
  assign push      = cpu_req & cpu_ready;
  assign issue     = vga_rdn & ~empty & ~rst & ~clr_access;

  genvar gi;
  generate
    for (gi = 0; gi < WQ_DEPTH; gi++) begin : g_entry
      logic [ENT_W-1:0] entry_reg;
      always_ff @(posedge vga_clk) begin
        if (push && wr_ptr_reg == PTR_W'(gi))
          entry_reg <= {cpu_we, cpu_addr, cpu_wdata};
      end
      assign fifo_mem[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (issue)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, issue})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
      cpu_rvalid <= issue & ~head_we;
      if (issue && !head_we)
        cpu_rdata <= head_in_range ? ram_dout : '0;
    end
  end

`ifdef VRAM_CLEAR_EN
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
  state_t            state_reg;
  logic [ADDR_W-1:0] clr_ptr_reg;
  logic [DATA_W-1:0] clr_data_reg;

  assign idle       = (state_reg == IDLE);
  assign clr_busy   = ~idle;
  assign clr_access = (state_reg == CLEAR) & vga_rdn & ~rst;
  assign clr_addr   = clr_ptr_reg;
  assign clr_wdata  = clr_data_reg;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      clr_ptr_reg  <= '0;
      clr_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (clr_start) begin
          clr_data_reg <= clr_data;
          state_reg    <= DRAIN;
        end
        // Backlogged CPU commands finish before the fill starts, preserving their order.
        DRAIN: if (empty) begin
          clr_ptr_reg <= '0;
          state_reg   <= CLEAR;
        end
        CLEAR: if (vga_rdn) begin
          if (clr_ptr_reg == LAST_ADDR)
            state_reg <= IDLE;
          else
            clr_ptr_reg <= clr_ptr_reg + ADDR_W'(1);
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
`else
  logic unused_clr;
  assign unused_clr = ^{clr_start, clr_data};
  assign idle       = 1'b1;
  assign clr_busy   = 1'b0;
  assign clr_access = 1'b0;
  assign clr_addr   = '0;
  assign clr_wdata  = '0;
`endif

  always_comb begin
    ram_addr = vga_addr;
    ram_we   = 1'b0;
    ram_din  = '0;
    if (vga_rdn) begin
      if (clr_access) begin
        ram_addr = clr_addr;
        ram_we   = 1'b1;
        ram_din  = clr_wdata;
      end else if (issue) begin
        ram_addr = head_addr;
        ram_we   = head_we & head_in_range;
        ram_din  = head_wdata;
      end
    end
  end

  assign vram_out = ram_dout;
endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed steps plus random traffic checked against an
// in-order command model (expected write stream, expected read values, shadow memory).
module tb_vram_arbiter;
  localparam int AW    = 13;
  localparam int DW    = 11;
  localparam int WORDS = 4800;

  logic          vga_clk = 1'b0;
  logic          rst = 1'b1;
  logic          vga_rdn = 1'b1;
  logic [AW-1:0] vga_addr = '0;
  logic [DW-1:0] vram_out;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          clr_start = 1'b0;
  logic [DW-1:0] clr_data = '0;
  logic          clr_busy;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0]    vram    [8192];
  logic [DW-1:0]    ref_mem [8192];
  logic [AW+DW-1:0] exp_wr[$];
  logic [DW-1:0]    exp_rd[$];
  logic [AW+DW-1:0] mon_e;
  logic [DW-1:0]    mon_r;
  int total = 0;
  int bad = 0;
  logic acc;
  logic found;

  vram_arbiter dut (
    .vga_clk(vga_clk), .rst(rst), .vga_rdn(vga_rdn), .vga_addr(vga_addr),
    .vram_out(vram_out), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .clr_start(clr_start), .clr_data(clr_data),
    .clr_busy(clr_busy), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 vga_clk = ~vga_clk;

  assign ram_dout = vram[ram_addr];
  always @(posedge vga_clk) if (ram_we) vram[ram_addr] <= ram_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Mid-cycle monitor: VGA ownership, write stream order, read data, and command acceptance.
  always @(negedge vga_clk) begin
    if (!rst) begin
      if (!vga_rdn) begin
        chk("vga_addr", 32'(ram_addr), 32'(vga_addr));
        chk("vga_no_we", 32'(ram_we), 32'd0);
        chk("vga_out", 32'(vram_out), 32'(vram[vga_addr]));
      end
      if (ram_we) begin
        chk("wr_pending", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          mon_e = exp_wr.pop_front();
          chk("wr_addr", 32'(ram_addr), 32'(mon_e[AW+DW-1:DW]));
          chk("wr_data", 32'(ram_din), 32'(mon_e[DW-1:0]));
        end
      end
      if (cpu_rvalid) begin
        chk("rd_pending", 32'(exp_rd.size() != 0), 32'd1);
        if (exp_rd.size() != 0) begin
          mon_r = exp_rd.pop_front();
          chk("rd_data", 32'(cpu_rdata), 32'(mon_r));
        end
      end
      if (cpu_req && cpu_ready) begin
        if (cpu_we) begin
          if (int'(cpu_addr) < WORDS) begin
            ref_mem[cpu_addr] = cpu_wdata;
            exp_wr.push_back({cpu_addr, cpu_wdata});
          end
        end else begin
          exp_rd.push_back((int'(cpu_addr) < WORDS) ? ref_mem[cpu_addr] : '0);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 8192; i++) begin
      vram[i]    = '0;
      ref_mem[i] = '0;
    end
    vram[4800] = 11'h555;
    acc   = 1'b0;
    found = 1'b0;

    // Reset values
    vga_addr = 13'h123;
    step(); step(); settle();
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'h123);
    chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_busy", 32'(clr_busy), 32'd0);
    rst = 1'b0;
    settle();
    chk("post_rst_ready", 32'(cpu_ready), 32'd1);
    step();

    // Write then read back with VGA idle
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'd5; cpu_wdata = 11'h741;
    settle(); chk("t1_ready", 32'(cpu_ready), 32'd1); step();
    cpu_req = 1'b0;
    settle();
    chk("t1_we", 32'(ram_we), 32'd1);
    chk("t1_addr", 32'(ram_addr), 32'd5);
    chk("t1_din", 32'(ram_din), 32'h741);
    step();
    cpu_req = 1'b1; cpu_we = 1'b0;
    settle(); step();
    cpu_req = 1'b0;
    settle(); chk("t1_rv_early", 32'(cpu_rvalid), 32'd0); step();
    settle();
    chk("t1_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("t1_rdata", 32'(cpu_rdata), 32'h741);
    step();
    settle(); chk("t1_rv_pulse", 32'(cpu_rvalid), 32'd0); step();

    // VGA collision: 3 busy cycles, 2 writes queued
    vga_rdn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vga_addr = 13'(200 + i);
      cpu_req = (i < 2); cpu_we = 1'b1;
      cpu_addr = 13'(32 + i); cpu_wdata = 11'(273 * (i + 1));
      settle();
      chk("col_addr", 32'(ram_addr), 32'(200 + i));
      chk("col_we", 32'(ram_we), 32'd0);
      step();
    end
    vga_rdn = 1'b1; cpu_req = 1'b0;
    settle(); chk("col_w1", 32'({ram_we, ram_addr, ram_din}), 32'({1'b1, 13'd32, 11'd273})); step();
    settle(); chk("col_w2", 32'({ram_we, ram_addr, ram_din}), 32'({1'b1, 13'd33, 11'd546})); step();
    settle(); chk("col_idle", 32'(ram_we), 32'd0); step();

    // FIFO full: 4 pushes under VGA, 5th held
    vga_rdn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b1;
      cpu_addr = 13'(48 + i); cpu_wdata = 11'(256 + i);
      settle(); chk("full_fill_ready", 32'(cpu_ready), 32'd1); step();
    end
    cpu_addr = 13'd52; cpu_wdata = 11'd260;
    settle(); chk("full_ready0", 32'(cpu_ready), 32'd0); step();
    settle(); chk("full_ready1", 32'(cpu_ready), 32'd0); step();
    vga_rdn = 1'b1;
    settle();
    chk("full_ready2", 32'(cpu_ready), 32'd0);
    chk("full_w0", 32'({ram_we, ram_addr}), 32'({1'b1, 13'd48}));
    step();
    settle();
    chk("full_ready3", 32'(cpu_ready), 32'd1);
    chk("full_w1", 32'({ram_we, ram_addr}), 32'({1'b1, 13'd49}));
    step();
    cpu_req = 1'b0;
    for (int i = 2; i < 5; i++) begin
      settle();
      chk("full_wn", 32'({ram_we, ram_addr, ram_din}), 32'({1'b1, 13'(48 + i), 11'(256 + i)}));
      step();
    end
    settle(); chk("full_done", 32'(ram_we), 32'd0); step();

    // Out-of-range writes and read
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'd4800; cpu_wdata = 11'h7ff;
    settle(); step();
    cpu_addr = 13'd8191;
    settle(); chk("oor_we_4800", 32'(ram_we), 32'd0); step();
    cpu_we = 1'b0; cpu_addr = 13'd4800;
    settle(); chk("oor_we_8191", 32'(ram_we), 32'd0); step();
    cpu_req = 1'b0;
    settle(); chk("oor_rd_issue", 32'({ram_we, ram_addr}), 32'({1'b0, 13'd4800})); step();
    settle();
    chk("oor_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("oor_rdata", 32'(cpu_rdata), 32'd0);
    step();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      vga_rdn  = ($urandom_range(0, 3) != 0);
      vga_addr = AW'($urandom_range(0, WORDS - 1));
      if (!cpu_req || acc) begin
        cpu_req   = ($urandom_range(0, 1) == 1);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(WORDS, 8191))
                                                : AW'($urandom_range(0, 15));
        cpu_wdata = DW'($urandom);
      end
      settle();
      acc = cpu_req && cpu_ready;
      step();
    end
    cpu_req = 1'b0; vga_rdn = 1'b1;
    for (int c = 0; c < 40 && (exp_wr.size() != 0 || exp_rd.size() != 0); c++) step();
    chk("rand_drain_wr", 32'(exp_wr.size()), 32'd0);
    chk("rand_drain_rd", 32'(exp_rd.size()), 32'd0);

    // Reset flushes queued commands
    vga_rdn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'(60 + i); cpu_wdata = 11'(i + 1);
      settle(); step();
    end
    cpu_req = 1'b0; rst = 1'b1;
    settle(); chk("flush_rst_ready", 32'(cpu_ready), 32'd0); step();
    exp_wr.delete(); exp_rd.delete();
    rst = 1'b0; vga_rdn = 1'b1;
    settle(); chk("flush_ready", 32'(cpu_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("flush_no_we", 32'(ram_we), 32'd0);
      step(); settle();
    end

`ifdef VRAM_CLEAR_EN
    // Clear with a 2-write backlog
    vga_rdn = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h40; cpu_wdata = 11'h0aa;
    settle(); step();
    cpu_addr = 13'h41; cpu_wdata = 11'h0bb;
    settle(); step();
    cpu_req = 1'b0; clr_start = 1'b1; clr_data = 11'h020;
    settle(); chk("clr_idle_before", 32'(clr_busy), 32'd0); step();
    clr_start = 1'b0;
    for (int a = 0; a < WORDS; a++) begin
      exp_wr.push_back({13'(a), 11'h020});
      ref_mem[a] = 11'h020;
    end
    for (int c = 0; c < 8000 && exp_wr.size() != 0; c++) begin
      vga_rdn  = ($urandom_range(0, 7) != 0);
      vga_addr = AW'($urandom_range(0, WORDS - 1));
      settle();
      chk("clr_busy", 32'(clr_busy), 32'd1);
      chk("clr_ready", 32'(cpu_ready), 32'd0);
      step();
    end
    vga_rdn = 1'b1;
    settle();
    chk("clr_all_written", 32'(exp_wr.size()), 32'd0);
    chk("clr_busy_end", 32'(clr_busy), 32'd0);
    chk("clr_ready_end", 32'(cpu_ready), 32'd1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h40;
    settle(); step();
    cpu_req = 1'b0;
    for (int c = 0; c < 10 && exp_rd.size() != 0; c++) step();
    chk("clr_readback", 32'(exp_rd.size()), 32'd0);

    // Reset while the fill pointer is at 100
    clr_start = 1'b1; clr_data = 11'h3ff;
    settle(); step();
    clr_start = 1'b0;
    for (int a = 0; a < WORDS; a++) exp_wr.push_back({13'(a), 11'h3ff});
    for (int c = 0; c < 300 && !found; c++) begin
      settle();
      if (ram_we && ram_addr == 13'd100) found = 1'b1;
      else step();
    end
    chk("mid_found", 32'(found), 32'd1);
    rst = 1'b1;
    step(); settle();
    chk("mid_busy", 32'(clr_busy), 32'd0);
    chk("mid_we", 32'(ram_we), 32'd0);
    exp_wr.delete();
    rst = 1'b0;
    settle(); chk("mid_ready", 32'(cpu_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(); settle();
      chk("mid_quiet", 32'({clr_busy, ram_we}), 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
